// File: rtl/seq_10010_pkg.sv
// Shared constants and FSM state type for the 10010 pattern family
// (transmitter and detectors).
package seq_10010_pkg;

    // Pattern bits, sent MSB first.
    localparam logic [4:0] PATTERN_10010 = 5'b10010;

    // Pattern length in bits.
    localparam int PAT_LEN = 5;

    // Bits shared by consecutive patterns when overlapped ("10" suffix == "10" prefix).
    localparam int OVL_10010 = 2;

    // Transmitter states.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/seq_gen_10010_tx.sv
// Serial transmitter for the 10010 sequence. A start request launches a run
// of 'count' patterns, MSB first, one bit per clock, optionally overlapping
// consecutive patterns by OVL bits.
//
// Handshake: start is a request qualified only by busy=0 (IDLE state, which
// includes the one-cycle done pulse). count and overlap are captured on the
// accepting edge; all three inputs are ignored while busy=1. There is no
// backpressure: once accepted, the run always completes unless reset.
module seq_gen_10010_tx
    import seq_10010_pkg::*;
#(
    parameter int                 PAT_LEN  = seq_10010_pkg::PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN  = PATTERN_10010,
    parameter int                 OVL      = OVL_10010,
    parameter int                 CNT_W    = 4,
    parameter logic               IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             overlap,
    output logic             dout,
    output logic             busy,
    output logic             frame_end,
    output logic             done,
    output logic             dbg_state
);

    localparam int IDX_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;

    // Bit index on which a full pattern starts, and on which an overlapped
    // follow-on pattern starts (the shared OVL bits are already on the line).
    localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(PAT_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_OVL   = IDX_W'(PAT_LEN - 1 - OVL);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;   // index of the bit currently on dout
    logic [CNT_W-1:0]   cnt_q, cnt_d;           // patterns still to send after the current one
    logic               ovl_q, ovl_d;
    logic               dout_q, dout_d;
    logic               busy_q, busy_d;
    logic               frame_end_q, frame_end_d;
    logic               done_q, done_d;

    // Storing "remaining after current" (count-1) keeps count = 2^CNT_W-1
    // inside the counter range with no wrap.

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        cnt_d       = cnt_q;
        ovl_d       = ovl_q;
        dout_d      = IDLE_BIT;
        busy_d      = 1'b0;
        frame_end_d = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && (count != '0)) begin
                    state_d     = SEND;
                    cnt_d       = count - CNT_W'(1);
                    ovl_d       = overlap;
                    bit_idx_d   = IDX_FIRST;
                    busy_d      = 1'b1;
                    dout_d      = PATTERN[IDX_FIRST];
                    frame_end_d = (IDX_FIRST == '0);
                end
            end

            SEND: begin
                if (bit_idx_q != '0) begin
                    // Mid-pattern: step to the next lower bit.
                    bit_idx_d   = bit_idx_q - IDX_W'(1);
                    busy_d      = 1'b1;
                    dout_d      = PATTERN[bit_idx_d];
                    frame_end_d = (bit_idx_d == '0);
                end else if (cnt_q != '0) begin
                    // Pattern finished, more to go: restart full or overlapped.
                    cnt_d       = cnt_q - CNT_W'(1);
                    bit_idx_d   = ovl_q ? IDX_OVL : IDX_FIRST;
                    busy_d      = 1'b1;
                    dout_d      = PATTERN[bit_idx_d];
                    frame_end_d = (bit_idx_d == '0);
                end else begin
                    // Final bit has been sent: drop to idle and pulse done.
                    state_d   = IDLE;
                    bit_idx_d = '0;
                    ovl_d     = 1'b0;
                    done_d    = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_idx_q   <= '0;
            cnt_q       <= '0;
            ovl_q       <= 1'b0;
            dout_q      <= IDLE_BIT;
            busy_q      <= 1'b0;
            frame_end_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            cnt_q       <= cnt_d;
            ovl_q       <= ovl_d;
            dout_q      <= dout_d;
            busy_q      <= busy_d;
            frame_end_q <= frame_end_d;
            done_q      <= done_d;
        end
    end

    assign dout      = dout_q;
    assign busy      = busy_q;
    assign frame_end = frame_end_q;
    assign done      = done_q;
    assign dbg_state = (state_q == SEND);

endmodule

// File: tb/tb_seq_gen_10010_tx.sv
// Bench for seq_gen_10010_tx: directed scenarios plus randomized runs,
// checked against a stream model built from the pattern rules.
module tb_seq_gen_10010_tx;

    localparam int PAT_LEN = 5;
    localparam int OVL     = 2;
    localparam int CNT_W   = 4;

    logic             clk;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] count;
    logic             overlap;
    logic             dout;
    logic             busy;
    logic             frame_end;
    logic             done;
    logic             dbg_state;

    logic [PAT_LEN-1:0] pat;
    int n_cmp;
    int n_err;

    seq_gen_10010_tx dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .count     (count),
        .overlap   (overlap),
        .dout      (dout),
        .busy      (busy),
        .frame_end (frame_end),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Run one transfer starting at the current negedge; returns at the
    // negedge of the done cycle with start low. noise=1 wiggles the inputs
    // during the run.
    task automatic do_run(input int n, input bit ov, input bit noise, input string tag);
        logic       exp_bit[$];
        logic       exp_fe[$];
        logic [4:0] obs;
        logic [4:0] exp;
        int first;
        int busy_cnt;
        int fe_cnt;
        int exp_len;

        // Behavioural model: concatenate patterns, dropping the shared bits.
        for (int p = 0; p < n; p++) begin
            first = (p == 0 || !ov) ? 0 : OVL;
            for (int i = first; i < PAT_LEN; i++) begin
                exp_bit.push_back(pat[PAT_LEN-1-i]);
                exp_fe.push_back(i == PAT_LEN - 1);
            end
        end
        exp_len = ov ? (PAT_LEN + (n - 1) * (PAT_LEN - OVL)) : (n * PAT_LEN);

        start   = 1'b1;
        count   = CNT_W'(n);
        overlap = ov;
        @(posedge clk);
        @(negedge clk);
        busy_cnt = 0;
        fe_cnt   = 0;
        for (int k = 0; k < exp_bit.size(); k++) begin
            obs = {dbg_state, dout, busy, frame_end, done};
            exp = {1'b1, exp_bit[k], 1'b1, exp_fe[k], 1'b0};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL %s bit%0d {state,dout,busy,fe,done}: got %b want %b", tag, k, obs, exp);
            end
            if (busy === 1'b1) busy_cnt++;
            if (frame_end === 1'b1) fe_cnt++;
            if (noise) begin
                start   = 1'($urandom_range(0, 1));
                count   = CNT_W'($urandom_range(0, 15));
                overlap = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        obs = {dbg_state, dout, busy, frame_end, done};
        n_cmp++;
        if (obs !== 5'b00001) begin
            n_err++;
            $display("FAIL %s done_cycle {state,dout,busy,fe,done}: got %b want 00001", tag, obs);
        end
        n_cmp++;
        if (busy_cnt != exp_len) begin
            n_err++;
            $display("FAIL %s busy_len: got %0d want %0d", tag, busy_cnt, exp_len);
        end
        n_cmp++;
        if (fe_cnt != n) begin
            n_err++;
            $display("FAIL %s frame_end_count: got %0d want %0d", tag, fe_cnt, n);
        end
    endtask

    // Check that the line stays idle for a number of cycles.
    task automatic expect_idle(input int cycles, input string tag);
        logic [4:0] obs;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            obs = {dbg_state, dout, busy, frame_end, done};
            n_cmp++;
            if (obs !== 5'b00000) begin
                n_err++;
                $display("FAIL %s idle%0d {state,dout,busy,fe,done}: got %b want 00000", tag, k, obs);
            end
        end
    endtask

    task automatic test_reset();
        logic [4:0] obs;
        reset   = 1'b1;
        start   = 1'b1;
        count   = 4'd5;
        overlap = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            obs = {dbg_state, dout, busy, frame_end, done};
            n_cmp++;
            if (obs !== 5'b00000) begin
                n_err++;
                $display("FAIL reset%0d {state,dout,busy,fe,done}: got %b want 00000", k, obs);
            end
        end
        reset = 1'b0;
        start = 1'b0;
        expect_idle(2, "post_reset");
    endtask

    task automatic test_directed();
        do_run(1, 1'b0, 1'b0, "single");
        expect_idle(1, "single_after");
        do_run(3, 1'b1, 1'b0, "ovl3");
        expect_idle(2, "ovl3_after");
        // Inputs toggled mid-run, then a new start in the done cycle.
        do_run(2, 1'b0, 1'b1, "full2_noise");
        do_run(1, 1'b0, 1'b0, "chained");
        expect_idle(1, "chained_after");
    endtask

    task automatic test_count_zero();
        start   = 1'b1;
        count   = '0;
        overlap = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        expect_idle(3, "count_zero");
    endtask

    task automatic test_max_count();
        do_run(15, 1'b1, 1'b0, "max_ovl");
        expect_idle(1, "max_after");
    endtask

    task automatic test_reset_mid_run();
        logic [4:0] obs;
        logic [4:0] exp;
        int idx;
        start   = 1'b1;
        count   = 4'd2;
        overlap = 1'b0;
        @(posedge clk);
        // Walk to bit 3 of the second pattern (8th bit on the line).
        for (int k = 0; k < PAT_LEN + 3; k++) begin
            @(negedge clk);
            start = 1'b0;
            idx = k % PAT_LEN;
            obs = {dbg_state, dout, busy, frame_end, done};
            exp = {1'b1, pat[PAT_LEN-1-idx], 1'b1, (idx == PAT_LEN - 1), 1'b0};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL abort_pre bit%0d {state,dout,busy,fe,done}: got %b want %b", k, obs, exp);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        obs = {dbg_state, dout, busy, frame_end, done};
        n_cmp++;
        if (obs !== 5'b00000) begin
            n_err++;
            $display("FAIL abort_reset {state,dout,busy,fe,done}: got %b want 00000", obs);
        end
        reset = 1'b0;
        expect_idle(3, "abort_no_done");
        do_run(1, 1'b0, 1'b0, "after_abort");
        expect_idle(1, "after_abort_idle");
    endtask

    task automatic test_back_to_back_random();
        int n;
        bit ov;
        for (int r = 0; r < 14; r++) begin
            n  = $urandom_range(1, 15);
            ov = 1'($urandom_range(0, 1));
            do_run(n, ov, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
            if ($urandom_range(0, 1) == 0) expect_idle($urandom_range(1, 3), "rnd_gap");
        end
        expect_idle(1, "rnd_end");
    endtask

    // Test sequence and final report
    initial begin
        n_cmp   = 0;
        n_err   = 0;
        pat     = 5'b10010;
        reset   = 1'b1;
        start   = 1'b0;
        count   = '0;
        overlap = 1'b0;
        test_reset();
        test_directed();
        test_count_zero();
        test_max_count();
        test_reset_mid_run();
        test_back_to_back_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
